// File: rtl/pc_sequencer.sv
// Single-step PC sequencer: synchronizes and debounces a push button, then walks one
// instruction step (sequential load, optional jump/branch reload) per press.
module pc_sequencer #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        btn_step_i,
  input  logic [31:0] pc_q_i,
  input  logic        dec_jump_i,
  input  logic        dec_branch_i,
  input  logic        dec_zero_i,
  input  logic [25:0] jump_index_i,
  input  logic [15:0] branch_off_i,
  output logic [31:0] pc_in_o,
  output logic        pc_enable_o,
  output logic        pc_jump_o,
  output logic        pc_branch_o,
  output logic        busy_o,
  output logic [15:0] step_count_o
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEQ    = 3'd1,
    CHECK  = 3'd2,
    TARGET = 3'd3,
    HOLD   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             db_q, db_d, db_prev_q;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [31:0]      target_q, target_d;
  logic             jump_q, jump_d;
  logic             branch_q, branch_d;
  logic [15:0]      step_count_q, step_count_d;
  logic             step_req;
  logic             br_taken;
  logic [31:0]      pc_plus4;
  logic [31:0]      br_disp;

  // Counter restarts whenever the synchronized level agrees with the accepted level.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == CNT_MAX) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  assign step_req = db_q & ~db_prev_q;
  assign br_taken = dec_branch_i & dec_zero_i;
  assign pc_plus4 = pc_q_i + 32'd4;
  assign br_disp  = {{14{branch_off_i[15]}}, branch_off_i, 2'b00};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_q         <= 1'b0;
      db_prev_q    <= 1'b0;
      db_cnt_q     <= '0;
      state_q      <= IDLE;
      target_q     <= '0;
      jump_q       <= 1'b0;
      branch_q     <= 1'b0;
      step_count_q <= '0;
    end else begin
      sync1_q      <= btn_step_i;
      sync2_q      <= sync1_q;
      db_q         <= db_d;
      db_prev_q    <= db_q;
      db_cnt_q     <= db_cnt_d;
      state_q      <= state_d;
      target_q     <= target_d;
      jump_q       <= jump_d;
      branch_q     <= branch_d;
      step_count_q <= step_count_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    jump_d       = jump_q;
    branch_d     = branch_q;
    step_count_d = step_count_q;
    pc_in_o      = pc_plus4;
    pc_enable_o  = 1'b0;
    pc_jump_o    = 1'b0;
    pc_branch_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (step_req) state_d = SEQ;
      end
      SEQ: begin
        pc_enable_o  = 1'b1;
        step_count_d = step_count_q + 16'd1;
        state_d      = CHECK;
      end
      CHECK: begin
        pc_jump_o   = dec_jump_i;
        pc_branch_o = br_taken;
        jump_d      = dec_jump_i;
        branch_d    = br_taken;
        if (dec_jump_i) begin
          target_d = {pc_plus4[31:28], jump_index_i, 2'b00};
          state_d  = TARGET;
        end else if (br_taken) begin
          target_d = pc_plus4 + br_disp;
          state_d  = TARGET;
        end else begin
          state_d = HOLD;
        end
      end
      TARGET: begin
        pc_enable_o = 1'b1;
        pc_in_o     = target_q;
        pc_jump_o   = jump_q;
        pc_branch_o = branch_q;
        state_d     = HOLD;
      end
      HOLD: begin
        if (!db_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o       = (state_q != IDLE);
  assign step_count_o = step_count_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter DB_CYCLES, default 4, is the number of consecutive stable cycles required to accept a new level on btn_step (range 1..2^20-1).
REQ-002 Clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Rst  input  1  one clock; reset is asynchronous and active-low.
REQ-004 btn_step  input  1  raw, asynchronous single-step push button; active-high.
REQ-005 pc_q  input  32  current program counter value from the PC register.
REQ-006 dec_jump  input  1  decoded instruction at pc_q is a jump; combinational from fetch/decode.
REQ-007 dec_branch  input  1  decoded instruction at pc_q is a branch.
REQ-008 dec_zero  input  1  ALU zero flag for the branch compare.
REQ-009 jump_index  input  26  jump target index field.
REQ-010 branch_off  input  16  signed branch word offset field.
REQ-011 pc_in  output  32  next address presented to the PC register.
REQ-012 pc_enable  output  1  one-cycle load strobe to the PC register.
REQ-013 pc_jump  output  1  tells the PC register a jump reload follows.
REQ-014 pc_branch  output  1  tells the PC register a taken-branch reload follows.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 step_count  output  16  number of completed steps, wraps 0xFFFF->0x0000.

Function
REQ-017 btn_step shall pass through a two-flop synchronizer, then a debouncer that updates the debounced level only after DB_CYCLES consecutive cycles of a synchronized level differing from it; any bounce restarts the count.
REQ-018 A step request shall be the rising edge of the debounced level; it is one cycle wide.
REQ-019 The FSM shall have states IDLE, SEQ, CHECK, TARGET, HOLD.
REQ-020 IDLE: all strobes low; on step request -> SEQ; otherwise remain.
REQ-021 SEQ (one cycle): pc_enable=1, pc_in=pc_q+4 (mod 2^32), pc_jump=pc_branch=0; -> CHECK.
REQ-022 CHECK (one cycle, pc_q now holds the new address): pc_jump=dec_jump, pc_branch=dec_branch&dec_zero, pc_enable=0.
REQ-023 CHECK: if dec_jump, latch target {pc_q+4 [31:28], jump_index, 2'b00} -> TARGET; jump has priority over branch when both are high.
REQ-024 CHECK: else if dec_branch&dec_zero, latch target pc_q+4+(sign-extended branch_off<<2), mod 2^32 -> TARGET.
REQ-025 CHECK: else (no jump, branch not taken) -> HOLD with no second strobe.
REQ-026 TARGET (one cycle): pc_enable=1, pc_in=latched target, pc_jump/pc_branch held at their CHECK values; -> HOLD.
REQ-027 HOLD: strobes low; -> IDLE when the debounced level is low; a held button shall never produce a second step.
REQ-028 step_count shall increment by 1 on the SEQ->CHECK transition.
REQ-029 pc_in shall read pc_q+4 in all states other than SEQ and TARGET; pc_enable shall never be high in two consecutive cycles.
REQ-030 busy shall equal (state != IDLE).
REQ-031 Step requests arriving while busy shall be ignored, not queued.

Reset
REQ-032 While Rst=0: state=IDLE, pc_enable=0, pc_jump=0, pc_branch=0, busy=0, step_count=0, latched target=0, synchronizer and debounced level=0, debounce counter=0.
REQ-033 Reset asserted mid-sequence, including in TARGET, shall abort the sequence immediately with no further strobe after release.
REQ-034 After Rst release, a button already held high shall count as a fresh rising edge once debounced.

Verification
REQ-035 Plain step: pc_q=0x00000010, no jump/branch, press button -> after sync+DB_CYCLES, exactly one pc_enable pulse with pc_in=0x00000014, no second pulse, step_count=1.
REQ-036 Jump: after SEQ, pc_q=0x00400020, dec_jump=1, jump_index=0x0000100 -> CHECK pc_jump=1, next cycle pc_enable=1 with pc_in=0x00000400.
REQ-037 Taken branch: pc_q=0x00000100, dec_branch=1, dec_zero=1, branch_off=0xFFFE -> second pulse with pc_in=0x000000FC and pc_branch=1; with dec_zero=0, no second pulse and pc_branch=0.
REQ-038 Bounce/hold: button toggled with runs shorter than DB_CYCLES, then held 100 cycles -> exactly one step; release then press again -> second step, step_count=2.
REQ-039 Wrap and reset: step_count preset to 0xFFFF via steps, one more step -> 0x0000; Rst pulsed low during TARGET -> all outputs zero, no strobe after release.
